// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: synchronises raw clock/data, receives frames, decodes
// make/break/E0 sequences and keeps an ordered table of held keys.
// Optional: define PS2_PARITY_CHECK_EN to drop frames whose odd parity fails.
module ps2_key_tracker #(
  parameter int MAX_KEYS       = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          psClk,
  input  logic                          psData,
  output logic [MAX_KEYS*9-1:0]         keys,
  output logic [$clog2(MAX_KEYS+1)-1:0] keyCount,
  output logic                          press,
  output logic                          newKey,
  output logic                          frameErr,
  output logic                          overflow
);

  localparam int CW = $clog2(MAX_KEYS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rxState_t;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} decState_t;

  logic [SYNC_STAGES-1:0] clkSync_q, dataSync_q;
  logic                   psClkPrev_q;
  logic                   clkS, dataS, fallEdge;

  rxState_t        rxState_q, rxState_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rxByte_q, rxByte_d;
  logic            byteValid_q, byteValid_d;
  logic            frameErr_q, frameErr_d;
  logic [TW-1:0]   toCnt_q, toCnt_d;
  logic            timeout;
  logic            parityOk;

  decState_t       decState_q, decState_d;
  logic            evValid, evExt, evBrk, ignoreByte;
  logic [8:0]      evKey;

  logic [MAX_KEYS-1:0][8:0] slots_q, slots_d, slotAbove;
  logic [CW-1:0]            count_q, count_d;
  logic                     press_q, press_d;
  logic                     newKey_q, newKey_d;
  logic                     overflow_q, overflow_d;
  logic [MAX_KEYS-1:0]      matchVec;
  logic                     hit, seen;

  // PS/2 lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clkSync_q   <= '1;
      dataSync_q  <= '1;
      psClkPrev_q <= 1'b1;
    end else begin
      clkSync_q   <= {clkSync_q[SYNC_STAGES-2:0], psClk};
      dataSync_q  <= {dataSync_q[SYNC_STAGES-2:0], psData};
      psClkPrev_q <= clkSync_q[SYNC_STAGES-1];
    end
  end

  assign clkS     = clkSync_q[SYNC_STAGES-1];
  assign dataS    = dataSync_q[SYNC_STAGES-1];
  assign fallEdge = psClkPrev_q & ~clkS;

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;
  assign parityOk = ^{shift_q, parity_q};
`else
  assign parityOk = 1'b1;
`endif

  always_comb begin
    rxState_d   = rxState_q;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    rxByte_d    = rxByte_q;
    byteValid_d = 1'b0;
    frameErr_d  = 1'b0;
    toCnt_d     = toCnt_q;
    timeout     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d    = parity_q;
`endif
    if (fallEdge) begin
      toCnt_d = '0;
      case (rxState_q)
        RX_IDLE: begin
          if (!dataS) begin
            rxState_d = RX_DATA;
            bitCnt_d  = '0;
          end
        end
        RX_DATA: begin
          shift_d  = {dataS, shift_q[7:1]};
          bitCnt_d = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) rxState_d = RX_PAR;
        end
        RX_PAR: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d  = dataS;
`endif
          rxState_d = RX_STOP;
        end
        default: begin
          rxState_d = RX_IDLE;
          if (dataS && parityOk) begin
            byteValid_d = 1'b1;
            rxByte_d    = shift_q;
          end else begin
            frameErr_d  = 1'b1;
          end
        end
      endcase
    end else if (rxState_q != RX_IDLE) begin
      if (toCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout    = 1'b1;
        frameErr_d = 1'b1;
        rxState_d  = RX_IDLE;
        toCnt_d    = '0;
      end else begin
        toCnt_d = toCnt_q + TW'(1);
      end
    end else begin
      toCnt_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rxState_q   <= RX_IDLE;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      rxByte_q    <= '0;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      toCnt_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      rxState_q   <= rxState_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      rxByte_q    <= rxByte_d;
      byteValid_q <= byteValid_d;
      frameErr_q  <= frameErr_d;
      toCnt_q     <= toCnt_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Keyboard status/ack bytes carry no key information and leave the decoder untouched.
  always_comb begin
    case (rxByte_q)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ignoreByte = 1'b1;
      default:                                  ignoreByte = 1'b0;
    endcase
  end

  always_comb begin
    decState_d = decState_q;
    evValid    = 1'b0;
    evExt      = (decState_q == D_EXT) || (decState_q == D_EXT_BRK);
    evBrk      = (decState_q == D_BRK) || (decState_q == D_EXT_BRK);
    evKey      = {evExt, rxByte_q};
    if (timeout) begin
      decState_d = D_IDLE;
    end else if (byteValid_q && !ignoreByte) begin
      if (rxByte_q == 8'hE0 && decState_q == D_IDLE) begin
        decState_d = D_EXT;
      end else if (rxByte_q == 8'hF0 && decState_q == D_IDLE) begin
        decState_d = D_BRK;
      end else if (rxByte_q == 8'hF0 && decState_q == D_EXT) begin
        decState_d = D_EXT_BRK;
      end else begin
        evValid    = 1'b1;
        decState_d = D_IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) decState_q <= D_IDLE;
    else        decState_q <= decState_d;
  end

  for (genvar g = 0; g < MAX_KEYS; g++) begin : gSlot
    assign matchVec[g] = (CW'(g) < count_q) && (slots_q[g] == evKey);
    if (g == MAX_KEYS - 1) begin : gTop
      assign slotAbove[g] = '0;
    end else begin : gMid
      assign slotAbove[g] = slots_q[g+1];
    end
  end

  assign hit = |matchVec;

  // Break: every slot from the matching one upward takes its upper neighbour,
  // which keeps the table ordered and zero-fills the vacated top slot.
  always_comb begin
    slots_d    = slots_q;
    count_d    = count_q;
    newKey_d   = 1'b0;
    overflow_d = 1'b0;
    seen       = 1'b0;
    if (evValid) begin
      if (!evBrk) begin
        if (!hit) begin
          if (count_q < CW'(MAX_KEYS)) begin
            for (int i = 0; i < MAX_KEYS; i++) begin
              if (CW'(i) == count_q) slots_d[i] = evKey;
            end
            count_d  = count_q + CW'(1);
            newKey_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end else if (hit) begin
        for (int i = 0; i < MAX_KEYS; i++) begin
          seen = seen | matchVec[i];
          if (seen) slots_d[i] = slotAbove[i];
        end
        count_d = count_q - CW'(1);
      end
    end
    press_d = (count_d != '0);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      slots_q    <= '0;
      count_q    <= '0;
      press_q    <= 1'b0;
      newKey_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      slots_q    <= slots_d;
      count_q    <= count_d;
      press_q    <= press_d;
      newKey_q   <= newKey_d;
      overflow_q <= overflow_d;
    end
  end

  assign keys     = slots_q;
  assign keyCount = count_q;
  assign press    = press_q;
  assign newKey   = newKey_q;
  assign overflow = overflow_q;
  assign frameErr = frameErr_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus pushes hand-computed expected
// observations, a monitor pops one whenever a pulse fires or the table changes.
module tb_ps2_key_tracker;

  localparam int MAX_KEYS = 4;
  localparam int TIMEOUT  = 400;
  localparam int HALF     = 100;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        psClk;
  logic        psData;
  logic [35:0] keys;
  logic [2:0]  keyCount;
  logic        press, newKey, frameErr, overflow;

  int checks = 0;
  int errors = 0;
  int evNum  = 0;
  logic [42:0] expQ[$];
  logic [35:0] prevKeys  = '0;
  logic [2:0]  prevCount = '0;
  logic        prevPress = 1'b0;

  ps2_key_tracker #(
    .MAX_KEYS(MAX_KEYS),
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .psClk(psClk),
    .psData(psData),
    .keys(keys),
    .keyCount(keyCount),
    .press(press),
    .newKey(newKey),
    .frameErr(frameErr),
    .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  function automatic logic [42:0] mkObs(input logic nk, input logic ov, input logic fe,
                                         input logic [35:0] k, input logic [2:0] cnt);
    return {nk, ov, fe, (cnt != 3'd0), cnt, k};
  endfunction

  task automatic checkOutput(input string name, input logic [42:0] got, input logic [42:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got {nk,ov,fe,press,cnt,keys}=%h expected %h", name, got, exp);
    end
  endtask

  task automatic pushExp(input logic nk, input logic ov, input logic fe,
                         input logic [35:0] k, input logic [2:0] cnt);
    expQ.push_back(mkObs(nk, ov, fe, k, cnt));
  endtask

  // Bits go out start, data LSB first, odd parity, stop; device samples on psClk fall.
  task automatic applyStimulus(input logic [7:0] data, input bit badStop,
                               input bit badParity, input int nBits);
    logic [10:0] frame;
    frame = {~badStop, (~^data) ^ badParity, data, 1'b0};
    for (int b = 0; b < nBits; b++) begin
      psData = frame[b];
      #(HALF);
      psClk = 1'b0;
      #(HALF);
      psClk = 1'b1;
    end
    psData = 1'b1;
    #(HALF * 10);
  endtask

  task automatic sendByte(input logic [7:0] data);
    applyStimulus(data, 1'b0, 1'b0, 11);
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      if (newKey || overflow || frameErr || keys !== prevKeys ||
          keyCount !== prevCount || press !== prevPress) begin
        evNum++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event%0d: got {nk,ov,fe,press,cnt,keys}=%h expected none",
                   evNum, {newKey, overflow, frameErr, press, keyCount, keys});
        end else begin
          checkOutput($sformatf("event%0d", evNum),
                      {newKey, overflow, frameErr, press, keyCount, keys}, expQ.pop_front());
        end
      end
    end
    prevKeys  = keys;
    prevCount = keyCount;
    prevPress = press;
  end

  initial begin
    int waitCycles;
    Reset  = 1'b0;
    psClk  = 1'b1;
    psData = 1'b1;
    #23;
    checkOutput("reset_init", {newKey, overflow, frameErr, press, keyCount, keys}, 43'h0);
    Reset = 1'b1;
    #100;

    applyStimulus(8'h1D, 1'b0, 1'b0, 4);
    Reset = 1'b0;
    #50;
    checkOutput("reset_midframe", {newKey, overflow, frameErr, press, keyCount, keys}, 43'h0);
    Reset = 1'b1;
    #200;

    pushExp(1, 0, 0, {9'h000, 9'h000, 9'h000, 9'h01D}, 3'd1);
    sendByte(8'h1D);
    pushExp(1, 0, 0, {9'h000, 9'h000, 9'h01C, 9'h01D}, 3'd2);
    sendByte(8'h1C);
    pushExp(1, 0, 0, {9'h000, 9'h029, 9'h01C, 9'h01D}, 3'd3);
    sendByte(8'h29);
    pushExp(1, 0, 0, {9'h175, 9'h029, 9'h01C, 9'h01D}, 3'd4);
    sendByte(8'hE0); sendByte(8'h75);

    pushExp(0, 0, 0, {9'h000, 9'h175, 9'h029, 9'h01D}, 3'd3);
    sendByte(8'hF0); sendByte(8'h1C);
    pushExp(1, 0, 0, {9'h01C, 9'h175, 9'h029, 9'h01D}, 3'd4);
    sendByte(8'h1C);

    pushExp(0, 1, 0, {9'h01C, 9'h175, 9'h029, 9'h01D}, 3'd4);
    sendByte(8'h23);
    sendByte(8'h1D);
    pushExp(0, 0, 0, {9'h000, 9'h01C, 9'h175, 9'h029}, 3'd3);
    sendByte(8'hF0); sendByte(8'h1D);

    pushExp(0, 0, 1, {9'h000, 9'h01C, 9'h175, 9'h029}, 3'd3);
    applyStimulus(8'h33, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
    pushExp(0, 0, 1, {9'h000, 9'h01C, 9'h175, 9'h029}, 3'd3);
    applyStimulus(8'h33, 1'b0, 1'b1, 11);
`else
    pushExp(1, 0, 0, {9'h033, 9'h01C, 9'h175, 9'h029}, 3'd4);
    applyStimulus(8'h33, 1'b0, 1'b1, 11);
    pushExp(0, 0, 0, {9'h000, 9'h01C, 9'h175, 9'h029}, 3'd3);
    sendByte(8'hF0); sendByte(8'h33);
`endif

    pushExp(0, 0, 0, {9'h000, 9'h000, 9'h01C, 9'h029}, 3'd2);
    sendByte(8'hE0); sendByte(8'hFA); sendByte(8'hF0); sendByte(8'h75);
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
    pushExp(1, 0, 0, {9'h000, 9'h075, 9'h01C, 9'h029}, 3'd3);
    sendByte(8'h75);

    pushExp(0, 0, 0, {9'h000, 9'h000, 9'h075, 9'h01C}, 3'd2);
    sendByte(8'hF0); sendByte(8'h29);
    pushExp(0, 0, 0, {9'h000, 9'h000, 9'h000, 9'h075}, 3'd1);
    sendByte(8'hF0); sendByte(8'h1C);
    pushExp(0, 0, 0, 36'h0, 3'd0);
    sendByte(8'hF0); sendByte(8'h75);

    pushExp(0, 0, 1, 36'h0, 3'd0);
    applyStimulus(8'h00, 1'b0, 1'b0, 5);
    #(TIMEOUT * 10 + 2000);
    pushExp(1, 0, 0, {9'h000, 9'h000, 9'h000, 9'h029}, 3'd1);
    sendByte(8'h29);
    pushExp(0, 0, 0, 36'h0, 3'd0);
    sendByte(8'hF0); sendByte(8'hAA); sendByte(8'h29);

    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 5000) begin
      @(posedge Clk);
      waitCycles++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending events expected 0", expQ.size());
    end
    repeat (200) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
